// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Core, debug and memory-side signal bundle for dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12
);
  // core load/store port
  logic              core_req;
  logic              core_we;
  logic [2:0]        core_funct3;
  logic [31:0]       core_addr;
  logic [31:0]       core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [31:0]       core_rdata;
  logic              core_misalign;
  // debug/loader port
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;
  // data memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wren;
  logic [31:0]       mem_wrdata;
  logic [31:0]       mem_rddata;

  modport slave (
    input  core_req, core_we, core_funct3, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata, core_misalign,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_wren, mem_wrdata,
    input  mem_rddata
  );

  modport master (
    output core_req, core_we, core_funct3, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata, core_misalign,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_wren, mem_wrdata,
    output mem_rddata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Core/debug arbiter and RV32 sub-word formatter for a 4-bank data
//            memory. Optional misaligned-access trap: DMEM_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam logic [1:0] SZ_B         = 2'd0;
  localparam logic [1:0] SZ_H         = 2'd1;
  localparam logic [1:0] SZ_W         = 2'd2;
  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

  logic [1:0]  core_size;
  logic        core_uns;
  logic        core_mis;
  logic        core_win;
  logic        dbg_win;

  logic [3:0]  starve_cnt_q,  starve_cnt_d;
  logic        core_rvalid_q, core_rvalid_d;
  logic        dbg_rvalid_q,  dbg_rvalid_d;
  logic        misalign_q,    misalign_d;
  logic [1:0]  ld_size_q,     ld_size_d;
  logic        ld_uns_q,      ld_uns_d;
  logic [1:0]  ld_off_q,      ld_off_d;
  logic        ld_zero_q,     ld_zero_d;
  logic [31:0] core_rdata_q,  core_rdata_d;
  logic [31:0] dbg_rdata_q,   dbg_rdata_d;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_fmt;

  generate
    if (ADDR_W < 32) begin : g_addr_wrap
      logic unused_core_addr_hi;
      assign unused_core_addr_hi = ^bus.core_addr[31:ADDR_W];
    end else begin : g_addr_full
    end
  endgenerate

  logic unused_dbg_addr_lsb;
  assign unused_dbg_addr_lsb = ^bus.dbg_addr[1:0];

  // Invalid encodings fall through to word size.
  always_comb begin
    core_size = SZ_W;
    core_uns  = 1'b0;
    case (bus.core_funct3)
      3'b000:  core_size = SZ_B;
      3'b001:  core_size = SZ_H;
      3'b100: begin
        core_size = SZ_B;
        core_uns  = 1'b1;
      end
      3'b101: begin
        core_size = SZ_H;
        core_uns  = 1'b1;
      end
      default: core_size = SZ_W;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign core_mis = ((core_size == SZ_H) && bus.core_addr[0]) ||
                    ((core_size == SZ_W) && (bus.core_addr[1:0] != 2'b00));
`else
  assign core_mis = 1'b0;
`endif

  always_comb begin
    core_win = 1'b0;
    dbg_win  = 1'b0;
    if (!rst) begin
      if (bus.core_req && (!bus.dbg_req || (starve_cnt_q == C_STARVE_MAX))) begin
        core_win = 1'b1;
      end else if (bus.dbg_req) begin
        dbg_win = 1'b1;
      end
    end
  end

  assign bus.core_gnt = core_win;
  assign bus.dbg_gnt  = dbg_win;

  // Counts debug wins that overtook a waiting core.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.core_req || core_win) begin
      starve_cnt_d = 4'd0;
    end else if (dbg_win && (starve_cnt_q != C_STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    bus.mem_addr = '0;
    if (core_win) begin
      bus.mem_addr = bus.core_addr[ADDR_W-1:0];
    end else if (dbg_win) begin
      bus.mem_addr = {bus.dbg_addr[ADDR_W-1:2], 2'b00};
    end
  end

  always_comb begin
    bus.mem_wren   = 4'b0000;
    bus.mem_wrdata = 32'h0000_0000;
    if (core_win && bus.core_we && !core_mis) begin
      case (core_size)
        SZ_B: begin
          bus.mem_wrdata = {4{bus.core_wdata[7:0]}};
          bus.mem_wren   = 4'b0001 << bus.core_addr[1:0];
        end
        SZ_H: begin
          bus.mem_wrdata = {2{bus.core_wdata[15:0]}};
          bus.mem_wren   = 4'b0011 << {bus.core_addr[1], 1'b0};
        end
        default: begin
          bus.mem_wrdata = bus.core_wdata;
          bus.mem_wren   = 4'b1111;
        end
      endcase
    end else if (dbg_win && bus.dbg_we) begin
      bus.mem_wrdata = bus.dbg_wdata;
      bus.mem_wren   = 4'b1111;
    end
  end

  always_comb begin
    core_rvalid_d = core_win && !bus.core_we;
    dbg_rvalid_d  = dbg_win && !bus.dbg_we;
    misalign_d    = core_win && core_mis;
    ld_size_d     = ld_size_q;
    ld_uns_d      = ld_uns_q;
    ld_off_d      = ld_off_q;
    ld_zero_d     = ld_zero_q;
    if (core_win) begin
      ld_size_d = core_size;
      ld_uns_d  = core_uns;
      ld_off_d  = bus.core_addr[1:0];
      ld_zero_d = core_mis;
    end
  end

  // Read data arrives the cycle after the grant; format it from the latched attributes.
  always_comb begin
    ld_byte = bus.mem_rddata[7:0];
    case (ld_off_q)
      2'd0: ld_byte = bus.mem_rddata[7:0];
      2'd1: ld_byte = bus.mem_rddata[15:8];
      2'd2: ld_byte = bus.mem_rddata[23:16];
      2'd3: ld_byte = bus.mem_rddata[31:24];
      default: ld_byte = bus.mem_rddata[7:0];
    endcase
    ld_half  = ld_off_q[1] ? bus.mem_rddata[31:16] : bus.mem_rddata[15:0];
    load_fmt = bus.mem_rddata;
    case (ld_size_q)
      SZ_B:    load_fmt = {{24{~ld_uns_q & ld_byte[7]}}, ld_byte};
      SZ_H:    load_fmt = {{16{~ld_uns_q & ld_half[15]}}, ld_half};
      default: load_fmt = bus.mem_rddata;
    endcase
    if (ld_zero_q) begin
      load_fmt = 32'h0000_0000;
    end
  end

  assign core_rdata_d = core_rvalid_q ? load_fmt : core_rdata_q;
  assign dbg_rdata_d  = dbg_rvalid_q ? bus.mem_rddata : dbg_rdata_q;

  assign bus.core_rvalid   = core_rvalid_q;
  assign bus.dbg_rvalid    = dbg_rvalid_q;
  assign bus.core_misalign = misalign_q;
  assign bus.core_rdata    = core_rdata_d;
  assign bus.dbg_rdata     = dbg_rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q  <= 4'd0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      misalign_q    <= 1'b0;
      ld_size_q     <= SZ_B;
      ld_uns_q      <= 1'b0;
      ld_off_q      <= 2'd0;
      ld_zero_q     <= 1'b0;
      core_rdata_q  <= 32'h0000_0000;
      dbg_rdata_q   <= 32'h0000_0000;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      core_rvalid_q <= core_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
      misalign_q    <= misalign_d;
      ld_size_q     <= ld_size_d;
      ld_uns_q      <= ld_uns_d;
      ld_off_q      <= ld_off_d;
      ld_zero_q     <= ld_zero_d;
      core_rdata_q  <= core_rdata_d;
      dbg_rdata_q   <= dbg_rdata_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed stimulus for dmem_arbiter against a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  localparam int ADDR_W     = 12;
  localparam int STARVE_MAX = 4;
  localparam int NWORDS     = 1 << (ADDR_W - 2);
  localparam int NBYTES     = 1 << ADDR_W;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Four byte-lane banks with synchronous read.
  logic [31:0] mem [0:NWORDS-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= 32'h0;
      bus.mem_rddata <= 32'h0;
    end else begin
      bus.mem_rddata <= mem[bus.mem_addr[ADDR_W-1:2]];
      for (int l = 0; l < 4; l++)
        if (bus.mem_wren[l]) mem[bus.mem_addr[ADDR_W-1:2]][8*l +: 8] <= bus.mem_wrdata[8*l +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_bytes [0:NBYTES-1];
  int          m_wait;
  bit          m_pc, m_pd, m_mis;
  logic [31:0] m_cexp, m_dexp, m_crd, m_drd;
  bit          eg_c, eg_d;
  logic [3:0]  e_wren;
  logic [31:0] e_wdat;
  logic [ADDR_W-1:0] e_addr;

  function automatic logic [31:0] m_word(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] b;
    b = {a[ADDR_W-1:2], 2'b00};
    return {m_bytes[b+3], m_bytes[b+2], m_bytes[b+1], m_bytes[b]};
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    logic [7:0]  by;
    logic [15:0] hw;
    w  = m_word(a);
    by = 8'(w >> (8 * a[1:0]));
    hw = 16'(w >> (16 * a[1]));
    case (f3)
      3'b000:  return {{24{by[7]}}, by};
      3'b100:  return {24'h0, by};
      3'b001:  return {{16{hw[15]}}, hw};
      3'b101:  return {16'h0, hw};
      default: return w;
    endcase
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    if (!TRAP) return 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) return lo[0];
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
    return lo != 2'b00;
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         output logic [3:0] wren, output logic [31:0] wdat);
    logic [ADDR_W-1:0] b;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      m_bytes[a] = d[7:0];
      wren = 4'(1 << a[1:0]);
      wdat = {4{d[7:0]}};
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      b = {a[ADDR_W-1:1], 1'b0};
      m_bytes[b]   = d[7:0];
      m_bytes[b+1] = d[15:8];
      wren = a[1] ? 4'b1100 : 4'b0011;
      wdat = {2{d[15:0]}};
    end else begin
      b = {a[ADDR_W-1:2], 2'b00};
      for (int k = 0; k < 4; k++) m_bytes[b+k] = d[8*k +: 8];
      wren = 4'b1111;
      wdat = d;
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_core_gnt",    32'(bus.core_gnt),      32'd0);
        chk("rst_dbg_gnt",     32'(bus.dbg_gnt),       32'd0);
        chk("rst_mem_wren",    32'(bus.mem_wren),      32'd0);
        chk("rst_core_rvalid", 32'(bus.core_rvalid),   32'd0);
        chk("rst_dbg_rvalid",  32'(bus.dbg_rvalid),    32'd0);
        chk("rst_misalign",    32'(bus.core_misalign), 32'd0);
        chk("rst_core_rdata",  bus.core_rdata,         32'd0);
        chk("rst_dbg_rdata",   bus.dbg_rdata,          32'd0);
        m_wait = 0; m_pc = 0; m_pd = 0; m_mis = 0; m_crd = 0; m_drd = 0;
        for (int i = 0; i < NBYTES; i++) m_bytes[i] = 8'h00;
      end else begin
        if (m_pc) m_crd = m_cexp;
        if (m_pd) m_drd = m_dexp;
        chk("core_rvalid",   32'(bus.core_rvalid),   32'(m_pc));
        chk("core_rdata",    bus.core_rdata,         m_crd);
        chk("core_misalign", 32'(bus.core_misalign), 32'(m_mis));
        chk("dbg_rvalid",    32'(bus.dbg_rvalid),    32'(m_pd));
        chk("dbg_rdata",     bus.dbg_rdata,          m_drd);

        eg_c = bus.core_req && (!bus.dbg_req || m_wait >= STARVE_MAX);
        eg_d = bus.dbg_req && !eg_c;
        chk("core_gnt", 32'(bus.core_gnt), 32'(eg_c));
        chk("dbg_gnt",  32'(bus.dbg_gnt),  32'(eg_d));

        e_wren = 4'b0000; e_wdat = 32'h0; e_addr = '0;
        m_pc = 0; m_pd = 0; m_mis = 0;
        if (eg_c) begin
          e_addr = bus.core_addr[ADDR_W-1:0];
          m_mis  = m_misaligned(bus.core_funct3, bus.core_addr[1:0]);
          if (bus.core_we) begin
            if (!m_mis) m_store(bus.core_funct3, e_addr, bus.core_wdata, e_wren, e_wdat);
          end else begin
            m_pc   = 1;
            m_cexp = m_mis ? 32'h0 : m_load(bus.core_funct3, e_addr);
          end
        end else if (eg_d) begin
          e_addr = bus.dbg_addr;
          if (bus.dbg_we) m_store(3'b010, bus.dbg_addr, bus.dbg_wdata, e_wren, e_wdat);
          else begin
            m_pd   = 1;
            m_dexp = m_word(bus.dbg_addr);
          end
        end
        chk("mem_word_addr", 32'(bus.mem_addr[ADDR_W-1:2]), 32'(e_addr[ADDR_W-1:2]));
        chk("mem_wren", 32'(bus.mem_wren), 32'(e_wren));
        if (e_wren != 4'b0000) chk("mem_wrdata", bus.mem_wrdata, e_wdat);

        if (!bus.core_req || eg_c) m_wait = 0;
        else if (eg_d && m_wait < STARVE_MAX) m_wait++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic core_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         output logic [3:0] wren, output logic [31:0] wdat,
                         output logic [31:0] rd, output logic rv, output logic mis);
    int n;
    @(posedge clk); #1;
    bus.core_req = 1'b1; bus.core_we = we; bus.core_funct3 = f3;
    bus.core_addr = a; bus.core_wdata = d;
    n = 0;
    @(negedge clk);
    while (!bus.core_gnt && n < 20) begin n++; @(negedge clk); end
    chk("core_gnt_wait", 32'(bus.core_gnt), 32'd1);
    wren = bus.mem_wren; wdat = bus.mem_wrdata;
    @(posedge clk); #1;
    bus.core_req = 1'b0;
    @(negedge clk);
    rd = bus.core_rdata; rv = bus.core_rvalid; mis = bus.core_misalign;
  endtask

  task automatic dbg_op(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic rv);
    int n;
    @(posedge clk); #1;
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    n = 0;
    @(negedge clk);
    while (!bus.dbg_gnt && n < 20) begin n++; @(negedge clk); end
    chk("dbg_gnt_wait", 32'(bus.dbg_gnt), 32'd1);
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    rd = bus.dbg_rdata; rv = bus.dbg_rvalid;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0]  wr;
    logic [31:0] wd, rd;
    logic        rv, mis;
    logic [9:0]  pat;
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_funct3 = 3'b010;
    bus.core_addr = 32'h0; bus.core_wdata = 32'h0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = '0; bus.dbg_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1; bus.core_req = 1'b0; bus.dbg_req = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    core_op(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, wr, wd, rd, rv, mis);
    chk("sw_wren", 32'(wr), 32'h0000000F);
    core_op(1'b0, 3'b010, 32'h010, 32'h0, wr, wd, rd, rv, mis);
    chk("lw_rvalid", 32'(rv), 32'd1);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    dbg_op(1'b0, 12'h010, 32'h0, rd, rv);
    chk("dbg_lw_rdata", rd, 32'hDEADBEEF);

    core_op(1'b1, 3'b000, 32'h013, 32'h00000080, wr, wd, rd, rv, mis);
    chk("sb_wren", 32'(wr), 32'h00000008);
    chk("sb_wrdata", wd, 32'h80808080);
    core_op(1'b0, 3'b000, 32'h013, 32'h0, wr, wd, rd, rv, mis);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    core_op(1'b0, 3'b100, 32'h013, 32'h0, wr, wd, rd, rv, mis);
    chk("lbu_rdata", rd, 32'h00000080);

    core_op(1'b1, 3'b001, 32'h022, 32'h00008001, wr, wd, rd, rv, mis);
    chk("sh_wren", 32'(wr), 32'h0000000C);
    chk("sh_wrdata", wd, 32'h80018001);
    core_op(1'b0, 3'b001, 32'h022, 32'h0, wr, wd, rd, rv, mis);
    chk("lh_rdata", rd, 32'hFFFF8001);
    core_op(1'b0, 3'b101, 32'h022, 32'h0, wr, wd, rd, rv, mis);
    chk("lhu_rdata", rd, 32'h00008001);

    dbg_op(1'b1, 12'h050, 32'hA5A55A5A, rd, rv);
    core_op(1'b0, 3'b101, 32'h052, 32'h0, wr, wd, rd, rv, mis);
    chk("lhu_hi_rdata", rd, 32'h0000A5A5);
    core_op(1'b0, 3'b000, 32'h050, 32'h0, wr, wd, rd, rv, mis);
    chk("lb_pos_rdata", rd, 32'h0000005A);
    core_op(1'b0, 3'b011, 32'h010, 32'h0, wr, wd, rd, rv, mis);
    chk("inv_f3_rdata", rd, 32'h80ADBEEF);

    // both ports requesting continuously
    @(posedge clk); #1;
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_funct3 = 3'b010; bus.core_addr = 32'h010;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 12'h020;
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat = {pat[8:0], bus.core_gnt};
    end
    @(posedge clk); #1;
    bus.core_req = 1'b0; bus.dbg_req = 1'b0;
    chk("starve_pattern", 32'(pat), 32'(10'b0000100001));

    // load then store on consecutive cycles
    @(posedge clk); #1;
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_funct3 = 3'b010; bus.core_addr = 32'h010;
    @(negedge clk);
    @(posedge clk); #1;
    bus.core_we = 1'b1; bus.core_addr = 32'h040; bus.core_wdata = 32'h12345678;
    @(negedge clk);
    chk("b2b_lw_rdata", bus.core_rdata, 32'h80ADBEEF);
    @(posedge clk); #1;
    bus.core_req = 1'b0;
    dbg_op(1'b0, 12'h040, 32'h0, rd, rv);
    chk("b2b_sw_readback", rd, 32'h12345678);

    core_op(1'b1, 3'b010, 32'h030, 32'h11223344, wr, wd, rd, rv, mis);
    core_op(1'b1, 3'b010, 32'h031, 32'hCAFEF00D, wr, wd, rd, rv, mis);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_sw_wren", 32'(wr), 32'd0);
    chk("mis_sw_flag", 32'(mis), 32'd1);
    core_op(1'b0, 3'b010, 32'h030, 32'h0, wr, wd, rd, rv, mis);
    chk("mis_lw_prior", rd, 32'h11223344);
    core_op(1'b0, 3'b001, 32'h031, 32'h0, wr, wd, rd, rv, mis);
    chk("mis_lh_rvalid", 32'(rv), 32'd1);
    chk("mis_lh_rdata", rd, 32'h0);
    chk("mis_lh_flag", 32'(mis), 32'd1);
`else
    chk("mis_sw_wren", 32'(wr), 32'h0000000F);
    chk("mis_sw_flag", 32'(mis), 32'd0);
    core_op(1'b0, 3'b010, 32'h030, 32'h0, wr, wd, rd, rv, mis);
    chk("mis_lw_aligned", rd, 32'hCAFEF00D);
    core_op(1'b0, 3'b001, 32'h031, 32'h0, wr, wd, rd, rv, mis);
    chk("mis_lh_aligned", rd, 32'hFFFFF00D);
    chk("mis_lh_flag", 32'(mis), 32'd0);
`endif

    // reset while a load response is pending
    @(posedge clk); #1;
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_funct3 = 3'b010; bus.core_addr = 32'h010;
    @(negedge clk);
    chk("rst_test_gnt", 32'(bus.core_gnt), 32'd1);
    @(posedge clk); #1;
    bus.core_req = 1'b0;
    #2; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    rv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rv = rv | bus.core_rvalid;
    end
    chk("rst_rvalid_lost", 32'(rv), 32'd0);
    chk("rst_rdata_cleared", bus.core_rdata, 32'h0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the byte-lane data memory (four 8-bit banks, synchronous read) between the core load/store port and a debug/loader port.
- Performs RV32 sub-word formatting: byte-lane write enables, replicated store data, and sign/zero-extended load data.
- Sits between the MEM stage / debug bridge and the data memory. Grants one access per cycle with fixed debug priority and an anti-starvation counter for the core.

Parameters:
- ADDR_W, 12, byte-address width of the data memory; word address = addr[ADDR_W-1:2].
- STARVE_MAX, 4, consecutive debug grants allowed while core_req is pending before the core is forced one grant; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- core_req  in  1  core access request, held until granted
- core_we  in  1  1 = store, 0 = load
- core_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- core_addr  in  32  byte address; bits above ADDR_W-1 ignored (wrap)
- core_wdata  in  32  store data, right-aligned
- core_gnt  out  1  combinational grant, same cycle as the request
- core_rvalid  out  1  load data valid, one cycle after grant
- core_rdata  out  32  extended load data
- core_misalign  out  1  pulse one cycle after grant of a misaligned access
- dbg_req  in  1  debug word request
- dbg_we  in  1  debug store
- dbg_addr  in  ADDR_W  debug byte address; bits [1:0] ignored
- dbg_wdata  in  32  debug word data
- dbg_gnt  out  1  combinational grant
- dbg_rvalid  out  1  debug read data valid, one cycle after grant
- dbg_rdata  out  32  raw memory word
- mem_addr  out  ADDR_W  byte address to memory
- mem_wren  out  4  byte-lane write enables
- mem_wrdata  out  32  lane-replicated write data
- mem_rddata  in  32  memory read data; valid the cycle after the address is presented

Behaviour:
- Reset (async): core_rvalid, dbg_rvalid, core_misalign = 0; core_rdata, dbg_rdata = 0; starve counter = 0; registered load attributes cleared.
- While rst is high, all grants are forced to 0 and mem_wren is forced to 0.
- Arbitration, per cycle:
  - dbg_req wins, unless core_req is high and starve_cnt == STARVE_MAX; in that case the core wins.
  - Only one grant per cycle.
- Starve counter:
  - Increments on a debug grant while core_req is pending, saturating at STARVE_MAX.
  - Clears on any core grant, or in any cycle with core_req low.
- Address mux: mem_addr comes from the granted port; it is 0 when idle.
- Stores, in the grant cycle:
  - SB: wrdata = {4{wdata[7:0]}}, wren = 4'b0001 << addr[1:0].
  - SH: wrdata = {2{wdata[15:0]}}, wren = 4'b0011 << {addr[1],1'b0}.
  - SW and debug store: wrdata = wdata, wren = 4'b1111.
- Loads: wren = 0. funct3, addr[1:0] and requester ID are registered at grant.
- Load response, cycle T+1 (grant at T):
  - The granted port's rvalid pulses for exactly 1 cycle.
  - B/BU: select byte addr[1:0], then sign/zero extend.
  - H/HU: select half addr[1], then extend.
  - W: full word.
  - rdata holds its last value when rvalid is 0.
- Back-to-back: a new grant is allowed every cycle. A load at T and a store at T+1 are both legal; the response pipeline is 1 deep and never stalls.
- Invalid core funct3 (011, 110, 111): treated as W for alignment and lanes.
- Reset mid-operation: the pending rvalid is lost and no response is issued after reset releases.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned core accesses are H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0.
  - Such an access is still granted, but mem_wren is forced to 0.
  - At T+1, core_misalign pulses. For a load, core_rvalid also pulses with core_rdata = 0.
  - The starve counter behaves as for any core grant.
- Undefined:
  - core_misalign is tied to 0.
  - Low address bits are forced to alignment: H uses addr[1], W ignores [1:0].

Test Plan:
- Reset then SW addr 0x010 data 0xDEADBEEF, LW 0x010 -> mem_wren=1111; core_rvalid at T+1 with rdata 0xDEADBEEF.
- SB 0x013 data 0x80, then LB 0x013 and LBU 0x013 -> first store has wren=1000; LB returns 0xFFFFFF80 and LBU returns 0x00000080.
- SH 0x022 data 0x8001, then LH/LHU 0x022 -> wren=1100, wrdata=0x80018001; LH returns 0xFFFF8001 and LHU returns 0x00008001.
- core_req and dbg_req held continuously with STARVE_MAX=4 -> grant pattern is dbg×4, core×1, repeating; the counter never exceeds 4.
- With DMEM_MISALIGN_TRAP_EN, SW at 0x031 -> no write (wren=0000); core_misalign=1 at T+1, and a later LW 0x030 returns the prior contents.
- LW issued, then rst asserted in cycle T+1 before the edge -> core_rvalid stays 0 and core_rdata=0 after reset release.
